// File: rtl/game_pkg.sv
// Shared game-flow types: state encoding used by the controller, renderer and spawner.
// Event bundle groups the per-cycle pulses from the cut/collision logic.
package game_pkg;

  typedef enum logic [1:0] {
    ST_START = 2'd0,
    ST_PLAY  = 2'd1,
    ST_PAUSE = 2'd2,
    ST_OVER  = 2'd3
  } state_t;

  typedef struct packed {
    logic start_cut;
    logic fruit_cut;
    logic fruit_miss;
    logic bomb_cut;
    logic pause_toggle;
  } game_ev_t;

endpackage

// File: rtl/game_flow_ctrl_hold_timer.sv
// frame_hold_timer: counts frame_tick pulses while clear is low; done pulses combinationally on the
// OVER_FRAMES-th tick so the owner can leave its hold state on that same edge.
module frame_hold_timer #(
  parameter int OVER_FRAMES = 120,
  localparam int CNT_W = $clog2(OVER_FRAMES + 1)
) (
  input  logic Clk,
  input  logic Reset,
  input  logic clear,
  input  logic frame_tick,
  output logic done
);

  logic [CNT_W-1:0] count;

  assign done = frame_tick && !clear && (count == CNT_W'(OVER_FRAMES - 1));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (frame_tick && (count != CNT_W'(OVER_FRAMES))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game-flow controller START -> PLAY -> (PAUSE) -> OVER -> START; owns lives, score and OVER hold.
// Moore outputs from registered state; define GAME_FLOW_PAUSE_EN to add the PAUSE state.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int START_LIVES = 3,
  parameter int LIVES_W     = 3,
  parameter int SCORE_W     = 10,
  parameter int OVER_FRAMES = 120
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               start_cut,
  input  logic               frame_tick,
  input  logic               fruit_cut,
  input  logic               fruit_miss,
  input  logic               bomb_cut,
  input  logic               pause_toggle,
  output logic               start_screen,
  output logic               throw_fruit,
  output logic               end_screen,
  output logic               paused,
  output logic [LIVES_W-1:0] lives,
  output logic [SCORE_W-1:0] score,
  output logic [1:0]         game_state
);

  localparam logic [LIVES_W-1:0] LIVES_INIT = LIVES_W'(START_LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};

  state_t             state, state_nxt;
  logic [LIVES_W-1:0] lives_nxt;
  logic [SCORE_W-1:0] score_nxt;
  logic               hold_done;
  game_ev_t           ev;

  assign ev = '{start_cut:    start_cut,
                fruit_cut:    fruit_cut,
                fruit_miss:   fruit_miss,
                bomb_cut:     bomb_cut,
                pause_toggle: pause_toggle};

  // Timer is held clear outside OVER, so it always starts from zero on entry.
  frame_hold_timer #(
    .OVER_FRAMES(OVER_FRAMES)
  ) u_hold (
    .Clk       (Clk),
    .Reset     (Reset),
    .clear     (state != ST_OVER),
    .frame_tick(frame_tick),
    .done      (hold_done)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= ST_START;
      lives <= LIVES_INIT;
      score <= '0;
    end else begin
      state <= state_nxt;
      lives <= lives_nxt;
      score <= score_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    lives_nxt = lives;
    score_nxt = score;
    case (state)
      ST_START: begin
        if (ev.start_cut) begin
          state_nxt = ST_PLAY;
          lives_nxt = LIVES_INIT;
          score_nxt = '0;
        end
      end
      ST_PLAY: begin
        if (lives == '0) begin
          state_nxt = ST_OVER;
        end else if (ev.bomb_cut) begin
          lives_nxt = '0;
          state_nxt = ST_OVER;
        end else begin
          if (ev.fruit_miss) begin
            if (lives == LIVES_W'(1)) begin
              lives_nxt = '0;
              state_nxt = ST_OVER;
            end else begin
              lives_nxt = lives - 1'b1;
            end
          end
          // A slice lands even on the cycle the last life is lost.
          if (ev.fruit_cut && (score != SCORE_MAX)) begin
            score_nxt = score + 1'b1;
          end
`ifdef GAME_FLOW_PAUSE_EN
          if (ev.pause_toggle && (state_nxt == ST_PLAY)) begin
            state_nxt = ST_PAUSE;
          end
`endif
        end
      end
      ST_PAUSE: begin
`ifdef GAME_FLOW_PAUSE_EN
        if (ev.pause_toggle) begin
          state_nxt = ST_PLAY;
        end
`else
        state_nxt = ST_START;
`endif
      end
      ST_OVER: begin
        if (hold_done) begin
          state_nxt = ST_START;
        end
      end
      default: state_nxt = ST_START;
    endcase
  end

  assign start_screen = (state == ST_START);
  assign throw_fruit  = (state == ST_PLAY);
  assign end_screen   = (state == ST_OVER);
  assign game_state   = state;

`ifdef GAME_FLOW_PAUSE_EN
  assign paused = (state == ST_PAUSE);
`else
  logic unused_pause;
  assign unused_pause = ev.pause_toggle;
  assign paused       = 1'b0;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Scoreboard bench for game_flow_ctrl (SCORE_W=4 so saturation is reachable quickly).
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int SL = 3;
  localparam int LW = 3;
  localparam int SW = 4;
  localparam int OF = 120;

  logic          Clk = 1'b0;
  logic          Reset = 1'b1;
  logic          start_cut, frame_tick, fruit_cut, fruit_miss, bomb_cut, pause_toggle;
  logic          start_screen, throw_fruit, end_screen, paused;
  logic [LW-1:0] lives;
  logic [SW-1:0] score;
  logic [1:0]    game_state;

  always #5 Clk = ~Clk;

  game_flow_ctrl #(
    .START_LIVES(SL), .LIVES_W(LW), .SCORE_W(SW), .OVER_FRAMES(OF)
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .start_cut(start_cut), .frame_tick(frame_tick), .fruit_cut(fruit_cut),
    .fruit_miss(fruit_miss), .bomb_cut(bomb_cut), .pause_toggle(pause_toggle),
    .start_screen(start_screen), .throw_fruit(throw_fruit), .end_screen(end_screen),
    .paused(paused), .lives(lives), .score(score), .game_state(game_state)
  );

  typedef struct {
    state_t st;
    int     lv;
    int     sc;
  } exp_t;

  exp_t   exp_q[$];
  int     checks = 0;
  int     failures = 0;
  state_t m_st;
  int     m_lives, m_score, m_hold;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_st = ST_START; m_lives = SL; m_score = 0; m_hold = 0;
  endtask

  task automatic model_edge(input logic s, t, c, m, b, p);
    case (m_st)
      ST_START: if (s) begin m_st = ST_PLAY; m_lives = SL; m_score = 0; end
      ST_PLAY: begin
        if (m_lives == 0) begin
          m_st = ST_OVER; m_hold = 0;
        end else if (b) begin
          m_lives = 0; m_st = ST_OVER; m_hold = 0;
        end else begin
          if (m) begin
            m_lives = m_lives - 1;
            if (m_lives == 0) begin m_st = ST_OVER; m_hold = 0; end
          end
          if (c && m_score < (2**SW - 1)) m_score = m_score + 1;
`ifdef GAME_FLOW_PAUSE_EN
          if (p && m_st == ST_PLAY) m_st = ST_PAUSE;
`endif
        end
      end
      ST_PAUSE: if (p) m_st = ST_PLAY;
      ST_OVER: if (t) begin
        m_hold = m_hold + 1;
        if (m_hold == OF) begin m_st = ST_START; m_hold = 0; end
      end
      default: m_st = ST_START;
    endcase
  endtask

  task automatic compare_outputs(input string tag, input exp_t e);
    chk({tag, ".state"}, game_state, e.st);
    chk({tag, ".lives"}, lives, e.lv);
    chk({tag, ".score"}, score, e.sc);
    chk({tag, ".start_screen"}, start_screen, e.st == ST_START);
    chk({tag, ".throw_fruit"}, throw_fruit, e.st == ST_PLAY);
    chk({tag, ".end_screen"}, end_screen, e.st == ST_OVER);
    chk({tag, ".paused"}, paused, e.st == ST_PAUSE);
  endtask

  task automatic step(input string tag, input logic s, t, c, m, b, p);
    exp_t e;
    start_cut = s; frame_tick = t; fruit_cut = c; fruit_miss = m; bomb_cut = b; pause_toggle = p;
    model_edge(s, t, c, m, b, p);
    e.st = m_st; e.lv = m_lives; e.sc = m_score;
    exp_q.push_back(e);
    @(posedge Clk);
    #1;
    start_cut = 0; frame_tick = 0; fruit_cut = 0; fruit_miss = 0; bomb_cut = 0; pause_toggle = 0;
    if (exp_q.size() == 0) begin
      chk({tag, ".sb_underflow"}, 1, 0);
    end else begin
      e = exp_q.pop_front();
      compare_outputs(tag, e);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, ".state"}, game_state, ST_START);
    chk({tag, ".start_screen"}, start_screen, 1);
    chk({tag, ".throw_fruit"}, throw_fruit, 0);
    chk({tag, ".end_screen"}, end_screen, 0);
    chk({tag, ".paused"}, paused, 0);
    chk({tag, ".lives"}, lives, SL);
    chk({tag, ".score"}, score, 0);
  endtask

  initial begin
    start_cut = 0; frame_tick = 0; fruit_cut = 0; fruit_miss = 0; bomb_cut = 0; pause_toggle = 0;
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_reset("rst");
    Reset = 0;

    // Start and three misses down to game over
    step("t1_start", 1, 0, 0, 0, 0, 0);
    chk("t1_throw", throw_fruit, 1);
    chk("t1_lives", lives, 3);
    for (int i = 0; i < 3; i++) begin
      step("t2_miss", 0, 0, 0, 1, 0, 0);
      chk("t2_lives", lives, 2 - i);
    end
    chk("t2_end", end_screen, 1);
    chk("t2_throw", throw_fruit, 0);

    // OVER hold: events ignored, start_cut at tick 60 ignored
    step("t3_ev", 1, 0, 1, 1, 1, 1);
    for (int i = 1; i <= OF; i++) begin
      step("t3_tick", (i == 60), 1, 0, 0, 0, 0);
      if (i == OF - 1) chk("t3_still_over", end_screen, 1);
      if ((i % 3 == 0) && (i < OF)) step("t3_idle", 0, 0, 0, 0, 0, 0);
    end
    chk("t3_start", start_screen, 1);

    // Bomb beats a simultaneous fruit cut
    step("t4_start", 1, 0, 0, 0, 0, 0);
    repeat (5) step("t4_cut", 0, 0, 1, 0, 0, 0);
    step("t4_bomb", 0, 0, 1, 0, 1, 0);
    chk("t4_lives", lives, 0);
    chk("t4_score", score, 5);
    chk("t4_state", game_state, ST_OVER);
    repeat (OF) step("t4_tick", 0, 1, 0, 0, 0, 0);
    chk("t4_back", start_screen, 1);

    // Cut and miss together, then saturation
    step("t5_start", 1, 0, 0, 0, 0, 0);
    chk("t5_score_clr", score, 0);
    step("t5_miss", 0, 0, 0, 1, 0, 0);
    step("t5_cutmiss", 0, 0, 1, 1, 0, 0);
    chk("t5_cm_score", score, 1);
    chk("t5_cm_lives", lives, 1);
    repeat (17) step("t5_cut", 0, 0, 1, 0, 0, 0);
    chk("t5_sat", score, 15);
    step("t5_bomb", 0, 0, 0, 0, 1, 0);
    repeat (OF) step("t5_tick", 0, 1, 0, 0, 0, 0);

    // Pause behaviour depends on build
    step("t6_start", 1, 0, 0, 0, 0, 0);
    step("t6_pause", 0, 0, 0, 0, 0, 1);
`ifdef GAME_FLOW_PAUSE_EN
    chk("t6_paused", paused, 1);
    chk("t6_nothrow", throw_fruit, 0);
    step("t6_miss", 0, 0, 1, 1, 1, 0);
    chk("t6_lives_frozen", lives, 3);
    step("t6_resume", 0, 0, 0, 0, 0, 1);
    chk("t6_throw", throw_fruit, 1);
    chk("t6_lives", lives, 3);
`else
    chk("t6_paused", paused, 0);
    chk("t6_throw", throw_fruit, 1);
    step("t6_miss", 0, 0, 0, 1, 0, 0);
    chk("t6_lives", lives, 2);
    step("t6_toggle", 0, 0, 0, 0, 0, 1);
    chk("t6_still_play", throw_fruit, 1);
`endif

    // Asynchronous reset mid-game
    step("t7_cut", 0, 0, 1, 0, 0, 0);
    #2 Reset = 1;
    #1 check_reset("t7_rst");
    @(posedge Clk);
    #1 Reset = 0;
    model_reset();
    step("t7_post", 0, 0, 1, 1, 0, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
